// File: rtl/hd_transfer_ctrl_if.sv
// Signal bundle between the transfer sequencer, the CPU control unit, the hard_disk and data memory.
// Handshake: start is a one-cycle request honoured only while busy is low; done pulses once per accepted start.
interface hd_transfer_ctrl_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int HD_TRILHAS_BITS = 4,
    parameter int HD_SETORES_BITS = 4,
    parameter int MEM_ADDR_BITS   = 10
);
    logic                       start;
    logic                       dir;
    logic [HD_TRILHAS_BITS-1:0] trilha_in;
    logic [HD_SETORES_BITS:0]   setor_count;
    logic [MEM_ADDR_BITS-1:0]   mem_base;
    logic                       busy;
    logic                       done;

    logic [DATA_WIDTH-1:0]      hd_data_in;
    logic [HD_TRILHAS_BITS-1:0] trilha;
    logic [HD_SETORES_BITS-1:0] setor;
    logic [DATA_WIDTH-1:0]      hd_data_out;
    logic                       hdRead;
    logic                       hdWrite;

    logic [DATA_WIDTH-1:0]      mem_data_in;
    logic [MEM_ADDR_BITS-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]      mem_data_out;
    logic                       mem_write;

    modport slave (
        input  start, dir, trilha_in, setor_count, mem_base, hd_data_in, mem_data_in,
        output busy, done, trilha, setor, hd_data_out, hdRead, hdWrite,
               mem_addr, mem_data_out, mem_write
    );

    modport master (
        output start, dir, trilha_in, setor_count, mem_base, hd_data_in, mem_data_in,
        input  busy, done, trilha, setor, hd_data_out, hdRead, hdWrite,
               mem_addr, mem_data_out, mem_write
    );
endinterface

// File: rtl/hd_transfer_ctrl.sv
// Sequencer copying a block of words between one hard_disk track and data memory (LOAD: HD->mem, SAVE: mem->HD).
// Two cycles per word: ADDR presents the addresses, XFER fires the write strobe.
module hd_transfer_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int HD_TRILHAS_BITS = 4,
    parameter int HD_SETORES_BITS = 4,
    parameter int MEM_ADDR_BITS   = 10
) (
    input  logic        clock,
    input  logic        reset,
    hd_transfer_ctrl_if.slave bus,
    output logic [1:0]  fsm_state
);
    localparam int CW = HD_SETORES_BITS + 1;
    localparam logic [CW-1:0] FULL = CW'(2 ** HD_SETORES_BITS);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;

    state_t                     state;
    logic                       dir_q;
    logic [HD_TRILHAS_BITS-1:0] trilha_q;
    logic [CW-1:0]              count_q;
    logic [CW-1:0]              idx;
    logic [MEM_ADDR_BITS-1:0]   base_q;
    logic [CW-1:0]              idx_nx;
    logic [CW-1:0]              count_clamped;

    assign idx_nx        = idx + CW'(1);
    assign count_clamped = (bus.setor_count > FULL) ? FULL : bus.setor_count;
    assign fsm_state     = state;

    // Data paths are pure pass-through; the hard_disk gates its output with hdRead.
    assign bus.mem_data_out = (state == XFER && !dir_q) ? bus.hd_data_in  : '0;
    assign bus.hd_data_out  = (state == XFER &&  dir_q) ? bus.mem_data_in : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            dir_q         <= 1'b0;
            trilha_q      <= '0;
            count_q       <= '0;
            idx           <= '0;
            base_q        <= '0;
            bus.trilha    <= '0;
            bus.setor     <= '0;
            bus.mem_addr  <= '0;
            bus.hdRead    <= 1'b0;
            bus.hdWrite   <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        dir_q    <= bus.dir;
                        trilha_q <= bus.trilha_in;
                        count_q  <= count_clamped;
                        base_q   <= bus.mem_base;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        if (count_clamped != '0) begin
                            state        <= ADDR;
                            bus.trilha   <= bus.trilha_in;
                            bus.setor    <= '0;
                            bus.mem_addr <= bus.mem_base;
                            bus.hdRead   <= !bus.dir;
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    state         <= XFER;
                    bus.hdWrite   <= dir_q;
                    bus.mem_write <= !dir_q;
                end
                XFER: begin
                    idx           <= idx_nx;
                    bus.hdWrite   <= 1'b0;
                    bus.mem_write <= 1'b0;
                    // idx carries one extra bit so a full track ends only after the last sector.
                    if (idx_nx == count_q) begin
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.hdRead   <= 1'b0;
                        bus.trilha   <= '0;
                        bus.setor    <= '0;
                        bus.mem_addr <= '0;
                    end else begin
                        state        <= ADDR;
                        bus.trilha   <= trilha_q;
                        bus.setor    <= idx_nx[HD_SETORES_BITS-1:0];
                        bus.mem_addr <= base_q + MEM_ADDR_BITS'(idx_nx);
                        bus.hdRead   <= !dir_q;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/hd_transfer_ctrl.md
Name: hd_transfer_ctrl

Overview:
- Sequencer that moves a block of words between one hard_disk track and main memory.
- LOAD direction copies HD sectors to memory, used by the boot/program-load path.
- SAVE direction copies memory words to HD sectors.
- Sits between the CPU control unit (start/done handshake) and the hard_disk and data-memory ports. It owns hdRead, hdWrite, trilha and setor while busy.

Parameters:
DATA_WIDTH, 32, word width of HD and memory data.
HD_TRILHAS_BITS, 4, track address width.
HD_SETORES_BITS, 4, sector address width; a track holds 2**HD_SETORES_BITS words.
MEM_ADDR_BITS, 10, memory word-address width.

Ports:
clock  input  1  single system clock; all state updates on posedge. Also drives hard_disk write_clock and read_clock.
reset  input  1  synchronous, active-high.
start  input  1  one-cycle request; sampled only in IDLE.
dir  input  1  0 = LOAD (HD->mem), 1 = SAVE (mem->HD); latched at start.
trilha_in  input  HD_TRILHAS_BITS  track to transfer; latched at start.
setor_count  input  HD_SETORES_BITS+1  number of sectors, 0..2**HD_SETORES_BITS; latched at start.
mem_base  input  MEM_ADDR_BITS  first memory word address; latched at start.
hd_data_in  input  DATA_WIDTH  hard_disk dataOut.
mem_data_in  input  DATA_WIDTH  memory read data; 1-cycle registered latency.
trilha  output  HD_TRILHAS_BITS  to hard_disk.
setor  output  HD_SETORES_BITS  to hard_disk.
hd_data_out  output  DATA_WIDTH  to hard_disk data.
hdRead  output  1  to hard_disk.
hdWrite  output  1  to hard_disk.
mem_addr  output  MEM_ADDR_BITS  memory address.
mem_data_out  output  DATA_WIDTH  memory write data.
mem_write  output  1  memory write enable.
busy  output  1  high from the cycle after an accepted start through DONE.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: every output 0; state IDLE; internal counters 0.
- Reset asserted mid-transfer:
  - Return to IDLE on the next edge.
  - No further hdWrite or mem_write.
  - Words already written stay written.
  - done is not pulsed.
- States: IDLE, ADDR, XFER, DONE.
- IDLE:
  - start=1 latches dir, trilha_in, setor_count and mem_base.
  - The word index idx is cleared to 0.
  - Next state is ADDR if setor_count != 0, else DONE.
  - start while busy is ignored.
- ADDR:
  - trilha = latched track; setor = idx[HD_SETORES_BITS-1:0]; mem_addr = mem_base + idx, modulo 2**MEM_ADDR_BITS (wraps).
  - LOAD: hdRead=1.
  - SAVE: hdRead=0 and the memory read is issued.
  - Next state: XFER.
- XFER (address outputs unchanged):
  - LOAD: hdRead stays 1 (hard_disk output is gated combinationally by hdRead); mem_write=1; mem_data_out = hd_data_in.
  - SAVE: hdWrite=1; hd_data_out = mem_data_in.
  - idx increments.
  - If idx+1 == setor_count, next state is DONE; else ADDR.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Throughput: 2 cycles per word. A transfer of N words takes 2N+1 cycles from the accepted start edge to the done pulse. N=0 gives done on the cycle after start.
- Strobes are Moore outputs decoded from registered state.
- hdRead, hdWrite and mem_write are never high in IDLE.
- hdWrite and mem_write are never high in the same cycle.
- Full track (count = 2**HD_SETORES_BITS): setor runs 0..15. idx uses the extra bit, so no early termination occurs.
- setor_count values above 2**HD_SETORES_BITS are clamped to 2**HD_SETORES_BITS.

Test Plan:
- Preload HD[0][0..2] = 0x14020_0C8-style li/out/halt words (0x140200C8, 0x28400000, 0xFFFFFFFF). LOAD track 0, count 3, base 0x010 -> mem[0x010..0x012] hold the same words; done pulses 7 cycles after start; hdWrite never rises.
- LOAD with count 0 -> no hdRead or mem_write; done pulses on the next cycle; busy high for 1 cycle.
- LOAD track 2, count 16, base 0x3F8 -> setor sweeps 0..15; mem_addr wraps 0x3FF->0x000; 16 mem_write pulses; done at cycle 33.
- SAVE mem[0x100..0x104] = 1..5 to track 5, then LOAD track 5 to base 0x200 -> mem[0x200..0x204] = 1..5.
- Start SAVE count 8, pulse start again at cycle 3, assert reset at cycle 6 -> second start ignored; at most 3 hdWrite pulses; all outputs 0 after reset; no done.
- Hold start high continuously with count 1 -> back-to-back transfers each of 3 cycles with a 1-cycle IDLE between; done pulses 4 cycles apart.
